// File: rtl/pc_stack_if.sv
// Control-strobe and address-bus bundle between the instruction decoder and pc_stack.
// master = decoder side, slave = pc_stack.
interface pc_stack_if #(
  parameter int unsigned AW    = 16,
  parameter int unsigned SW    = 3,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned SPW = $clog2(DEPTH) + 1;

  logic [AW-1:0]  ai;
  logic [AW-1:0]  rel;
  logic           lrc;
  logic           brr;
  logic           call;
  logic           ret;
  logic           ini;
  logic           cub;
  logic           oe;
  logic           flt_clr;
  logic [AW-1:0]  ao;
  logic [SW-1:0]  is;
  logic [SPW-1:0] sp;
  logic           f_ovf;
  logic           f_unf;
  logic           f_win;

  modport master (
    output ai, rel, lrc, brr, call, ret, ini, cub, oe, flt_clr,
    input  ao, is, sp, f_ovf, f_unf, f_win
  );

  modport slave (
    input  ai, rel, lrc, brr, call, ret, ini, cub, oe, flt_clr,
    output ao, is, sp, f_ovf, f_unf, f_win
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with micro-step counter, absolute/relative load, hardware
// call/return stack and a fetch-window guard that forces a restart on a bad target.
module pc_stack #(
  parameter int unsigned   AW      = 16,
  parameter int unsigned   SW      = 3,
  parameter int unsigned   DEPTH   = 8,
  parameter logic [AW-1:0] RST_VEC = 16'h8000,
  parameter logic [AW-1:0] WIN_LO  = 16'h8000,
  parameter logic [AW-1:0] WIN_HI  = 16'hFFFC
) (
  input  logic       clk,
  input  logic       rst,
  pc_stack_if.slave  bus
);
  localparam int unsigned   LW       = $clog2(DEPTH);
  localparam logic [LW:0]   SP_FULL  = (LW+1)'(DEPTH);
  localparam logic [SW-1:0] STEP_MAX = '1;

  typedef enum logic [2:0] {
    A_IDLE, A_LRC, A_CALL, A_RET, A_BRR, A_INI, A_CUB
  } act_e;

  act_e          act;
  logic [AW-1:0] ac, ac_nxt, ac_inc;
  logic [SW-1:0] is_q, is_nxt;
  logic [LW:0]   sp_q, sp_nxt;
  logic [LW-1:0] top_idx;
  logic          push, set_ovf, set_unf, set_win;
  logic          f_ovf, f_unf, f_win;
  logic [AW-1:0] stk [DEPTH];

  assign ac_inc  = ac + AW'(1);
  assign top_idx = sp_q[LW-1:0] - LW'(1);

  always_comb begin
    act = A_IDLE;
    if      (bus.lrc)  act = A_LRC;
    else if (bus.call) act = A_CALL;
    else if (bus.ret)  act = A_RET;
    else if (bus.brr)  act = A_BRR;
    else if (bus.ini)  act = A_INI;
    else if (bus.cub)  act = A_CUB;
  end

  always_comb begin
    ac_nxt  = ac;
    is_nxt  = is_q;
    sp_nxt  = sp_q;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    set_win = 1'b0;
    unique case (act)
      A_LRC: begin
        ac_nxt = bus.ai;
        is_nxt = '0;
      end
      A_CALL: begin
        if (sp_q < SP_FULL) begin
          push   = 1'b1;
          ac_nxt = bus.ai;
          sp_nxt = sp_q + 1'b1;
          is_nxt = '0;
        end else begin
          set_ovf = 1'b1;
        end
      end
      A_RET: begin
        if (sp_q != '0) begin
          ac_nxt = stk[top_idx];
          sp_nxt = sp_q - 1'b1;
          is_nxt = '0;
        end else begin
          set_unf = 1'b1;
        end
      end
      A_BRR: begin
        ac_nxt = ac + bus.rel;
        is_nxt = '0;
      end
      A_INI: begin
        ac_nxt = ac_inc;
        is_nxt = '0;
      end
      A_CUB: begin
        ac_nxt = ac_inc;
        is_nxt = (is_q >= STEP_MAX - SW'(1)) ? '0 : is_q + SW'(2);
      end
      default: begin
        if (is_q == STEP_MAX) begin
          is_nxt = '0;
          ac_nxt = ac_inc;
        end else begin
          is_nxt = is_q + SW'(1);
        end
      end
    endcase
    // Guard overrides whatever the action computed, including its stack push.
    if (ac_nxt < WIN_LO || ac_nxt > WIN_HI) begin
      ac_nxt  = RST_VEC;
      is_nxt  = '0;
      sp_nxt  = '0;
      push    = 1'b0;
      set_win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ac    <= RST_VEC;
      is_q  <= '0;
      sp_q  <= '0;
      f_ovf <= 1'b0;
      f_unf <= 1'b0;
      f_win <= 1'b0;
    end else begin
      ac    <= ac_nxt;
      is_q  <= is_nxt;
      sp_q  <= sp_nxt;
      f_ovf <= set_ovf | (f_ovf & ~bus.flt_clr);
      f_unf <= set_unf | (f_unf & ~bus.flt_clr);
      f_win <= set_win | (f_win & ~bus.flt_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk[sp_q[LW-1:0]] <= ac_inc;
  end

  assign bus.ao    = bus.oe ? ac : 'z;
  assign bus.is    = is_q;
  assign bus.sp    = sp_q;
  assign bus.f_ovf = f_ovf;
  assign bus.f_unf = f_unf;
  assign bus.f_win = f_win;
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: reset, stepping, operand consume, call/return,
// stack limits, window guard, flag clearing, priority and asynchronous reset.
module tb_pc_stack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  pc_stack_if #(.AW(16), .SW(3), .DEPTH(8)) bus ();

  pc_stack #(
    .AW(16), .SW(3), .DEPTH(8),
    .RST_VEC(16'h8000), .WIN_LO(16'h8000), .WIN_HI(16'hFFFC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    bus.lrc = 1'b0; bus.brr = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.ini = 1'b0; bus.cub = 1'b0; bus.flt_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.ai = '0; bus.rel = '0; bus.oe = 1'b1;
    clear_strobes();
    rst = 1'b0;
    #12;
    total++; if (bus.ao !== 16'h8000) begin bad++; $display("FAIL reset_ao: got %h want 8000", bus.ao); end
    total++; if (bus.is !== 3'd0) begin bad++; $display("FAIL reset_is: got %0d want 0", bus.is); end
    total++; if (bus.sp !== 4'd0) begin bad++; $display("FAIL reset_sp: got %0d want 0", bus.sp); end
    total++; if ({bus.f_ovf, bus.f_unf, bus.f_win} !== 3'b000) begin bad++;
      $display("FAIL reset_flags: got %b want 000", {bus.f_ovf, bus.f_unf, bus.f_win}); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_idle();
    logic [15:0] exp_ac;
    logic [2:0]  exp_is;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_is = 3'(k % 8);
      exp_ac = 16'h8000 + 16'(k / 8);
      total++; if (bus.is !== exp_is) begin bad++; $display("FAIL idle_is[%0d]: got %0d want %0d", k, bus.is, exp_is); end
      total++; if (bus.ao !== exp_ac) begin bad++; $display("FAIL idle_ac[%0d]: got %h want %h", k, bus.ao, exp_ac); end
    end
  endtask

  task automatic test_cub();
    repeat (4) tick();
    total++; if (bus.is !== 3'd5 || bus.ao !== 16'h8001) begin bad++;
      $display("FAIL cub_pre: got is=%0d ac=%h want is=5 ac=8001", bus.is, bus.ao); end
    bus.cub = 1'b1;
    tick();
    total++; if (bus.is !== 3'd7 || bus.ao !== 16'h8002) begin bad++;
      $display("FAIL cub_1: got is=%0d ac=%h want is=7 ac=8002", bus.is, bus.ao); end
    tick();
    total++; if (bus.is !== 3'd0 || bus.ao !== 16'h8003) begin bad++;
      $display("FAIL cub_2: got is=%0d ac=%h want is=0 ac=8003", bus.is, bus.ao); end
    bus.cub = 1'b0;
  endtask

  task automatic test_call_ret();
    logic [15:0] exp_ac [4] = '{16'h9000, 16'hA000, 16'h9001, 16'h8011};
    logic [3:0]  exp_sp [4] = '{4'd1, 4'd2, 4'd1, 4'd0};
    bus.lrc = 1'b1; bus.ai = 16'h8010;
    tick();
    bus.lrc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.call = (i < 2);
      bus.ret  = (i >= 2);
      bus.ai   = (i == 0) ? 16'h9000 : 16'hA000;
      tick();
      total++; if (bus.ao !== exp_ac[i] || bus.sp !== exp_sp[i]) begin bad++;
        $display("FAIL call_ret[%0d]: got ac=%h sp=%0d want ac=%h sp=%0d", i, bus.ao, bus.sp, exp_ac[i], exp_sp[i]); end
    end
    clear_strobes();
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ac;
    bus.lrc = 1'b1; bus.ai = 16'h8000;
    tick();
    bus.lrc = 1'b0; bus.call = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.ai = 16'h8100 + 16'(i);
      tick();
    end
    bus.call = 1'b0;
    total++; if (bus.sp !== 4'd8) begin bad++; $display("FAIL ovf_sp: got %0d want 8", bus.sp); end
    total++; if (bus.ao !== 16'h8107) begin bad++; $display("FAIL ovf_ac: got %h want 8107", bus.ao); end
    total++; if (bus.f_ovf !== 1'b1 || bus.f_unf !== 1'b0) begin bad++;
      $display("FAIL ovf_flag: got ovf=%b unf=%b want ovf=1 unf=0", bus.f_ovf, bus.f_unf); end
    bus.ret = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp_ac = (j < 8) ? 16'h8108 - 16'(j) : 16'h8001;
      total++; if (bus.ao !== exp_ac || bus.sp !== 4'(8 - j)) begin bad++;
        $display("FAIL pop[%0d]: got ac=%h sp=%0d want ac=%h sp=%0d", j, bus.ao, bus.sp, exp_ac, 8 - j); end
    end
    tick();
    bus.ret = 1'b0;
    total++; if (bus.f_unf !== 1'b1 || bus.ao !== 16'h8001 || bus.sp !== 4'd0) begin bad++;
      $display("FAIL unf: got unf=%b ac=%h sp=%0d want unf=1 ac=8001 sp=0", bus.f_unf, bus.ao, bus.sp); end
  endtask

  task automatic test_flt_clr();
    bus.flt_clr = 1'b1;
    tick();
    total++; if ({bus.f_ovf, bus.f_unf, bus.f_win} !== 3'b000) begin bad++;
      $display("FAIL clr: got %b want 000", {bus.f_ovf, bus.f_unf, bus.f_win}); end
    bus.ret = 1'b1;
    tick();
    total++; if (bus.f_unf !== 1'b1) begin bad++; $display("FAIL set_wins: got %b want 1", bus.f_unf); end
    clear_strobes();
    tick();
    total++; if (bus.f_unf !== 1'b1) begin bad++; $display("FAIL sticky: got %b want 1", bus.f_unf); end
    bus.flt_clr = 1'b1;
    tick();
    bus.flt_clr = 1'b0;
    total++; if (bus.f_unf !== 1'b0) begin bad++; $display("FAIL clr2: got %b want 0", bus.f_unf); end
  endtask

  task automatic test_window();
    bus.lrc = 1'b1; bus.ai = 16'h8005;
    tick();
    bus.lrc = 1'b0; bus.call = 1'b1;
    tick();
    bus.call = 1'b0;
    total++; if (bus.sp !== 4'd1 || bus.ao !== 16'h8005) begin bad++;
      $display("FAIL win_pre: got sp=%0d ac=%h want sp=1 ac=8005", bus.sp, bus.ao); end
    bus.brr = 1'b1; bus.rel = 16'hFFF0;
    tick();
    bus.brr = 1'b0;
    total++; if (bus.ao !== 16'h8000 || bus.sp !== 4'd0 || bus.f_win !== 1'b1 || bus.is !== 3'd0) begin bad++;
      $display("FAIL win_brr: got ac=%h sp=%0d win=%b is=%0d want ac=8000 sp=0 win=1 is=0", bus.ao, bus.sp, bus.f_win, bus.is); end
    bus.flt_clr = 1'b1;
    tick();
    bus.flt_clr = 1'b0;
    total++; if (bus.f_win !== 1'b0) begin bad++; $display("FAIL win_clr: got %b want 0", bus.f_win); end
    bus.lrc = 1'b1; bus.ai = 16'h8020;
    tick();
    bus.lrc = 1'b0; bus.brr = 1'b1; bus.rel = 16'hFFF0;
    tick();
    bus.brr = 1'b0;
    total++; if (bus.ao !== 16'h8010 || bus.f_win !== 1'b0) begin bad++;
      $display("FAIL brr_back: got ac=%h win=%b want ac=8010 win=0", bus.ao, bus.f_win); end
    bus.lrc = 1'b1; bus.ai = 16'hFFFC;
    tick();
    bus.lrc = 1'b0;
    total++; if (bus.ao !== 16'hFFFC || bus.f_win !== 1'b0) begin bad++;
      $display("FAIL win_hi: got ac=%h win=%b want ac=fffc win=0", bus.ao, bus.f_win); end
    bus.ini = 1'b1;
    tick();
    bus.ini = 1'b0;
    total++; if (bus.ao !== 16'h8000 || bus.f_win !== 1'b1) begin bad++;
      $display("FAIL win_ini: got ac=%h win=%b want ac=8000 win=1", bus.ao, bus.f_win); end
    bus.flt_clr = 1'b1;
    tick();
    bus.flt_clr = 1'b0; bus.call = 1'b1; bus.ai = 16'h7000;
    tick();
    bus.call = 1'b0;
    total++; if (bus.ao !== 16'h8000 || bus.sp !== 4'd0 || bus.f_win !== 1'b1) begin bad++;
      $display("FAIL win_call: got ac=%h sp=%0d win=%b want ac=8000 sp=0 win=1", bus.ao, bus.sp, bus.f_win); end
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    total++; if (bus.f_unf !== 1'b1 || bus.sp !== 4'd0) begin bad++;
      $display("FAIL win_nopush: got unf=%b sp=%0d want unf=1 sp=0", bus.f_unf, bus.sp); end
    bus.flt_clr = 1'b1;
    tick();
    bus.flt_clr = 1'b0;
  endtask

  task automatic test_priority();
    bus.lrc = 1'b1; bus.ai = 16'h8000;
    tick();
    bus.lrc = 1'b0;
    repeat (3) tick();
    total++; if (bus.is !== 3'd3) begin bad++; $display("FAIL prio_pre: got is=%0d want 3", bus.is); end
    bus.lrc = 1'b1; bus.ini = 1'b1; bus.cub = 1'b1; bus.ai = 16'h8100;
    tick();
    clear_strobes();
    total++; if (bus.ao !== 16'h8100 || bus.is !== 3'd0) begin bad++;
      $display("FAIL prio_lrc: got ac=%h is=%0d want ac=8100 is=0", bus.ao, bus.is); end
    bus.call = 1'b1; bus.ret = 1'b1; bus.ai = 16'h8200;
    tick();
    clear_strobes();
    total++; if (bus.ao !== 16'h8200 || bus.sp !== 4'd1) begin bad++;
      $display("FAIL prio_call: got ac=%h sp=%0d want ac=8200 sp=1", bus.ao, bus.sp); end
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    total++; if (bus.ao !== 16'h8101 || bus.sp !== 4'd0) begin bad++;
      $display("FAIL prio_ret: got ac=%h sp=%0d want ac=8101 sp=0", bus.ao, bus.sp); end
  endtask

  task automatic test_async_reset();
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    bus.call = 1'b1; bus.ai = 16'h9000;
    tick();
    total++; if (bus.ao !== 16'h9000 || bus.sp !== 4'd1 || bus.f_unf !== 1'b1) begin bad++;
      $display("FAIL ar_pre: got ac=%h sp=%0d unf=%b want ac=9000 sp=1 unf=1", bus.ao, bus.sp, bus.f_unf); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus.ao !== 16'h8000 || bus.is !== 3'd0 || bus.sp !== 4'd0 ||
                 {bus.f_ovf, bus.f_unf, bus.f_win} !== 3'b000) begin bad++;
      $display("FAIL ar_async: got ac=%h is=%0d sp=%0d flags=%b want 8000 0 0 000",
               bus.ao, bus.is, bus.sp, {bus.f_ovf, bus.f_unf, bus.f_win}); end
    tick();
    bus.call = 1'b0;
    total++; if (bus.ao !== 16'h8000 || bus.sp !== 4'd0) begin bad++;
      $display("FAIL ar_hold: got ac=%h sp=%0d want ac=8000 sp=0", bus.ao, bus.sp); end
    rst = 1'b1;
    tick();
    total++; if (bus.ao !== 16'h8000 || bus.is !== 3'd1) begin bad++;
      $display("FAIL ar_release: got ac=%h is=%0d want ac=8000 is=1", bus.ao, bus.is); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cub();
    test_call_ret();
    test_overflow();
    test_flt_clr();
    test_window();
    test_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
